// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the writeback register file and its neighbours
// (ID/EX, EX/MEM, forwarding unit).
package wb_regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_rdport.sv
// One combinational read port: hardwired-zero r0, optional same-cycle
// write-through bypass, otherwise the array contents.
module wb_regfile_rdport
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    logic is_zero;
    logic hit;

    always_comb begin
        is_zero = (addr == ADDR_W'(REG_ZERO));
        hit     = BYPASS && wr_en && (wr_addr == addr);
        if (is_zero) begin
            data = '0;
        end else if (hit) begin
            data = wr_data;
        end else begin
            data = reg_data;
        end
    end

endmodule : wb_regfile_rdport

// File: rtl/wb_regfile.sv
// MEM/WB consumer: writeback select, 32-entry register file with two bypassed
// read ports for ID, and a saturating committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [DATA_W-1:0] aluresult_i,
    input  logic [ADDR_W-1:0] writeaddr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wbdata_o,
    output logic              wbvalid_o,
    output logic [CNT_W-1:0]  wrcount_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  wrcount;
    logic              byp_en;

    always_comb begin
        wbdata_o  = memtoreg_i ? memdata_i : aluresult_i;
        wbvalid_o = regwrite_i && (writeaddr_i != ADDR_W'(REG_ZERO));
        // Bypass is gated by reset so both read ports hold 0 while rst_i is low.
        byp_en    = wbvalid_o && rst_i;
        wrcount_o = wrcount;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wrcount <= '0;
        end else if (wbvalid_o) begin
            regs[writeaddr_i] <= wbdata_o;
            if (wrcount != '1) begin
                wrcount <= wrcount + CNT_W'(1);
            end
        end
    end

    wb_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport_rs (
        .addr     (rs_addr_i),
        .reg_data (regs[rs_addr_i]),
        .wr_en    (byp_en),
        .wr_addr  (writeaddr_i),
        .wr_data  (wbdata_o),
        .data     (rs_data_o)
    );

    wb_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rdport_rt (
        .addr     (rt_addr_i),
        .reg_data (regs[rt_addr_i]),
        .wr_en    (byp_en),
        .wr_addr  (writeaddr_i),
        .wr_data  (wbdata_o),
        .data     (rt_data_o)
    );

endmodule : wb_regfile

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer side of the MEM/WB pipeline register: takes the registered writeback controls, memory data, ALU result and destination address.
- Selects the writeback value and commits it to a 32-entry general-purpose register file.
- Serves the ID stage through two combinational read ports with same-cycle write-through bypass, so that a writeback and a decode-stage read of the same register resolve without an extra stall cycle.
- Exposes the selected writeback value for the forwarding unit and keeps a saturating count of committed writes.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read bypass enabled; 0 = reads return array contents only
- CNT_W, 32, width of the committed-write counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  asynchronous, active-low reset
- regwrite_i  input  1  writeback enable from MEM/WB
- memtoreg_i  input  1  1 = write memdata_i, 0 = write aluresult_i
- memdata_i  input  DATA_W  load data from MEM/WB
- aluresult_i  input  DATA_W  ALU result from MEM/WB
- writeaddr_i  input  ADDR_W  destination register from MEM/WB
- rs_addr_i  input  ADDR_W  read port A address (ID stage)
- rt_addr_i  input  ADDR_W  read port B address (ID stage)
- rs_data_o  output  DATA_W  read port A data
- rt_data_o  output  DATA_W  read port B data
- wbdata_o  output  DATA_W  selected writeback value, to forwarding mux
- wbvalid_o  output  1  regwrite_i AND writeaddr_i != 0, to forwarding unit
- wrcount_o  output  CNT_W  committed-write count

Behaviour:
- Reset: while rst_i = 0, asynchronously clear all registers and wrcount_o to 0. While rst_i is low, rs_data_o = rt_data_o = 0 and wrcount_o = 0. A write presented while rst_i is low is discarded. Release is synchronous to the next rising edge; the first write can commit on the first rising edge with rst_i = 1.
- wbdata_o = memtoreg_i ? memdata_i : aluresult_i. Purely combinational.
- wbvalid_o = regwrite_i & (writeaddr_i != 0). Purely combinational.
- Write: on a rising edge, if wbvalid_o is 1, set reg[writeaddr_i] <= wbdata_o. Writes to register 0 are ignored and do not count.
- Register 0 reads 0 always, including when a write targets it.
- Read port A, combinational:
  - rs_addr_i == 0 -> 0
  - else if BYPASS and wbvalid_o and writeaddr_i == rs_addr_i -> wbdata_o
  - else reg[rs_addr_i]
- Read port B: identical rule using rt_addr_i.
- Both ports may address the same register, or the write target, in the same cycle; each resolves independently under the rule above.
- BYPASS = 0: a read in the write cycle returns the old value. The new value is visible from the cycle after the edge.
- Counter: on each edge with wbvalid_o = 1, wrcount_o increments by 1. It saturates at all-ones and does not wrap.
- No X propagation: with clean inputs, every output is defined from reset onward.
- No state machine. Sequential state is the register array plus the counter only; latency write-to-read is 0 cycles with bypass, 1 cycle without.

Decomposition:
- Shared package: DATA_W / ADDR_W defaults and the REG_ZERO = 0 constant, shared with ID/EX, EX/MEM and the forwarding unit.
- One natural sub-module: wb_regfile_rdport, instantiated twice. It contains the address-zero check, the bypass compare and the data mux for one read port.
- The array, write logic, writeback select and counter stay in the top.

Test Plan:
- Reset: assert rst_i = 0 mid-run after writing 0xDEADBEEF to r5 -> rs_data_o with rs_addr = 5 reads 0 immediately; wrcount_o = 0; after release, r5 reads 0.
- Write/read ALU path: regwrite = 1, memtoreg = 0, aluresult = 0x12345678, writeaddr = 8, one edge; then regwrite = 0, rs_addr = 8 -> rs_data_o = 0x12345678; wrcount_o = 1.
- Memory path plus bypass: regwrite = 1, memtoreg = 1, memdata = 0xCAFEF00D, writeaddr = 3, rs_addr = rt_addr = 3, before the edge -> both outputs = 0xCAFEF00D in the same cycle. With BYPASS = 0 the outputs show the old value until after the edge.
- r0 immunity: regwrite = 1, writeaddr = 0, aluresult = 0xFFFFFFFF -> wbvalid_o = 0; rs_data_o at addr 0 = 0; wrcount_o unchanged.
- Independent ports: write r9 = 0x11 on the prior edge; now write r10 = 0x22 with rs = 9, rt = 10 -> rs_data_o = 0x11, rt_data_o = 0x22.
- Counter saturation: with CNT_W = 4, perform 20 valid writes -> wrcount_o stops at 0xF.
